// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel programmable clock divider.
package clkdiv_pkg;

   localparam int DEFAULT_DIV = 50_000_000;
   localparam int MAX_CH      = 16;

   // Channel-select width: at least one bit, even for a single channel.
   function automatic int sel_width(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/shadow divisor, tick pulse and 50%-duty clkout.
module clkdiv_channel #(
   parameter int W           = 26,
   parameter int DEFAULT_DIV = clkdiv_pkg::DEFAULT_DIV
) (
   input  logic         clkin,
   input  logic         reset,
   input  logic         en,
   input  logic         sync,
   input  logic         wr,
   input  logic [W-1:0] wr_val,
   output logic         clkout,
   output logic         tick,
   output logic         pending
);
   import clkdiv_pkg::*;

   logic [W-1:0] cnt;
   logic [W-1:0] div_act;
   logic [W-1:0] div_sh;

   logic [W-1:0] cnt_nxt;
   logic [W-1:0] act_nxt;
   logic [W-1:0] sh_nxt;
   logic         clk_nxt;
   logic         tick_nxt;
   logic         pend_nxt;

   always_comb begin
      cnt_nxt  = cnt;
      act_nxt  = div_act;
      sh_nxt   = div_sh;
      clk_nxt  = clkout;
      tick_nxt = 1'b0;
      pend_nxt = pending;

      if (sync) begin
         cnt_nxt = '0;
         clk_nxt = 1'b0;
         if (pending) begin
            act_nxt  = div_sh;
            pend_nxt = 1'b0;
         end
      end else if (en && (div_act != '0)) begin
         if (cnt == div_act - W'(1)) begin
            cnt_nxt  = '0;
            tick_nxt = 1'b1;
            clk_nxt  = ~clkout;
            if (pending) begin
               act_nxt  = div_sh;
               pend_nxt = 1'b0;
            end
         end else begin
            cnt_nxt = cnt + W'(1);
         end
      end

      // Writes see the divisor as it stands after any sync or wrap commit this edge.
      if (wr) begin
         if (act_nxt == '0) begin
            act_nxt  = wr_val;
            cnt_nxt  = '0;
            pend_nxt = 1'b0;
         end else begin
            sh_nxt   = wr_val;
            pend_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clkin) begin
      if (reset) begin
         cnt     <= '0;
         div_act <= W'(DEFAULT_DIV);
         div_sh  <= '0;
         clkout  <= 1'b0;
         tick    <= 1'b0;
         pending <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         div_act <= act_nxt;
         div_sh  <= sh_nxt;
         clkout  <= clk_nxt;
         tick    <= tick_nxt;
         pending <= pend_nxt;
      end
   end

endmodule

// File: rtl/clock_divider_multi.sv
// N-channel programmable clock divider: decodes divisor writes per channel and fans out sync.
module clock_divider_multi #(
   parameter  int N_CH        = 4,
   parameter  int W           = 26,
   parameter  int DEFAULT_DIV = clkdiv_pkg::DEFAULT_DIV,
   localparam int CW          = clkdiv_pkg::sel_width(N_CH)
) (
   input  logic            clkin,
   input  logic            reset,
   input  logic [N_CH-1:0] en,
   input  logic            sync,
   input  logic            div_wr,
   input  logic [CW-1:0]   div_ch,
   input  logic [W-1:0]    div_val,
   output logic [N_CH-1:0] clkout,
   output logic [N_CH-1:0] tick,
   output logic [N_CH-1:0] pending
);
   import clkdiv_pkg::*;

   // Only existing channels decode a strobe, so out-of-range selects fall through silently.
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic wr_sel;
      assign wr_sel = div_wr && (div_ch == CW'(i));

      clkdiv_channel #(
         .W           (W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clkin   (clkin),
         .reset   (reset),
         .en      (en[i]),
         .sync    (sync),
         .wr      (wr_sel),
         .wr_val  (div_val),
         .clkout  (clkout[i]),
         .tick    (tick[i]),
         .pending (pending[i])
      );
   end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi: cycle table for steady ticking and divisor update,
// plus hand sequences for halt/reload, sync, enable freeze, invalid select, D=1 and reset.
module tb_clock_divider_multi;
   localparam int N_CH = 4;
   localparam int W    = 8;
   localparam int DEF  = 5;

   logic            clkin = 1'b0;
   logic            reset = 1'b1;
   logic [N_CH-1:0] en = '0;
   logic            sync = 1'b0;
   logic            div_wr = 1'b0;
   logic [1:0]      div_ch = '0;
   logic [W-1:0]    div_val = '0;
   logic [N_CH-1:0] clkout, tick, pending;

   logic            wr3 = 1'b0;
   logic [1:0]      ch3 = '0;
   logic [2:0]      clkout3, tick3, pending3;

   int n_cmp = 0;
   int n_bad = 0;

   clock_divider_multi #(.N_CH(N_CH), .W(W), .DEFAULT_DIV(DEF)) dut (
      .clkin(clkin), .reset(reset), .en(en), .sync(sync), .div_wr(div_wr),
      .div_ch(div_ch), .div_val(div_val), .clkout(clkout), .tick(tick), .pending(pending)
   );

   // Three-channel instance: select code 3 has no channel behind it.
   clock_divider_multi #(.N_CH(3), .W(W), .DEFAULT_DIV(DEF)) dut3 (
      .clkin(clkin), .reset(reset), .en(en[2:0]), .sync(sync), .div_wr(wr3),
      .div_ch(ch3), .div_val(div_val), .clkout(clkout3), .tick(tick3), .pending(pending3)
   );

   always #5 clkin = ~clkin;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic step(input logic [3:0] e, input logic s, input logic w,
                       input logic [1:0] c, input logic [W-1:0] v);
      @(negedge clkin);
      en = e; sync = s; div_wr = w; div_ch = c; div_val = v;
      @(posedge clkin);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clkin);
      reset = 1'b1; en = '0; sync = 1'b0; div_wr = 1'b0; wr3 = 1'b0;
      repeat (2) @(posedge clkin);
      #1;
      reset = 1'b0;
   endtask

   typedef struct {
      logic [3:0] en;
      logic       wr;
      logic [1:0] ch;
      logic [7:0] val;
      logic [3:0] tick;
      logic [3:0] clk;
      logic [3:0] pend;
   } vec_t;

   vec_t       tab[19];
   logic [3:0] exp4[7];
   logic       exp6[4];

   initial begin
      // D=5 on all channels; ch1 gets 3 written at cnt=1 and commits at the edge-10 wrap.
      tab[0]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0};
      tab[1]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0};
      tab[2]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0};
      tab[3]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0};
      tab[4]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'hF, 4'hF, 4'h0};
      tab[5]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h0, 4'hF, 4'h0};
      tab[6]  = '{4'hF, 1'b1, 2'd1, 8'd3, 4'h0, 4'hF, 4'h2};
      tab[7]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h0, 4'hF, 4'h2};
      tab[8]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h0, 4'hF, 4'h2};
      tab[9]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'hF, 4'h0, 4'h0};
      tab[10] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0};
      tab[11] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0};
      tab[12] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h2, 4'h2, 4'h0};
      tab[13] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h0, 4'h2, 4'h0};
      tab[14] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'hD, 4'hF, 4'h0};
      tab[15] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h2, 4'hD, 4'h0};
      tab[16] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h0, 4'hD, 4'h0};
      tab[17] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h0, 4'hD, 4'h0};
      tab[18] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h2, 4'hF, 4'h0};

      // Reset state.
      do_reset();
      chk("rst_tick", tick, 4'h0);
      chk("rst_clkout", clkout, 4'h0);
      chk("rst_pending", pending, 4'h0);
      chk("rst_pending3", pending3, 3'h0);

      for (int i = 0; i < 19; i++) begin
         step(tab[i].en, 1'b0, tab[i].wr, tab[i].ch, tab[i].val);
         chk($sformatf("tab%0d_tick", i + 1), tick, tab[i].tick);
         chk($sformatf("tab%0d_clkout", i + 1), clkout, tab[i].clk);
         chk($sformatf("tab%0d_pending", i + 1), pending, tab[i].pend);
      end

      // Write 0 to running ch2 (halts after wrap), then 4 loads immediately.
      do_reset();
      step(4'hF, 1'b0, 1'b1, 2'd2, 8'd0);
      chk("halt_pend_set", pending, 4'h4);
      for (int i = 0; i < 3; i++) step(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
      step(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
      chk("halt_wrap_tick", tick, 4'hF);
      chk("halt_wrap_pend", pending, 4'h0);
      for (int i = 0; i < 2; i++) begin
         step(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
         chk($sformatf("halted_tick_e%0d", i + 6), tick, 4'h0);
      end
      chk("halted_clk2", clkout[2], 1'b1);
      step(4'hF, 1'b0, 1'b1, 2'd2, 8'd4);
      chk("reload_pend", pending, 4'h0);
      chk("reload_tick2", tick[2], 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
         chk($sformatf("reload_wait_tick2_%0d", i), tick[2], 1'b0);
      end
      step(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
      chk("reload_tick2_d4", tick[2], 1'b1);
      chk("reload_clk2", clkout[2], 1'b0);

      // ch0 D=2, ch3 D=7 pending; sync mid-count commits both and realigns.
      exp4 = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h6, 4'h1, 4'h8};
      do_reset();
      step(4'hF, 1'b0, 1'b1, 2'd0, 8'd2);
      step(4'hF, 1'b0, 1'b1, 2'd3, 8'd7);
      chk("sync_pre_pend", pending, 4'h9);
      step(4'hF, 1'b1, 1'b0, 2'd0, 8'd0);
      chk("sync_pend", pending, 4'h0);
      chk("sync_clkout", clkout, 4'h0);
      chk("sync_tick", tick, 4'h0);
      for (int i = 0; i < 7; i++) begin
         step(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
         chk($sformatf("sync_e%0d_tick", i + 4), tick, exp4[i]);
      end
      chk("sync_e10_clkout", clkout, 4'hF);
      step(4'hF, 1'b1, 1'b1, 2'd1, 8'd3);
      chk("sync_wr_pend", pending, 4'h2);
      chk("sync_wr_tick", tick, 4'h0);
      chk("sync_wr_clkout", clkout, 4'h0);

      // ch0 disabled for six cycles mid-count; invalid select on the 3-channel instance.
      do_reset();
      step(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
      step(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
      step(4'hE, 1'b0, 1'b0, 2'd0, 8'd0);
      wr3 = 1'b1; ch3 = 2'd3;
      step(4'hE, 1'b0, 1'b0, 2'd0, 8'd2);
      wr3 = 1'b0;
      chk("bad_sel_pend3", pending3, 3'h0);
      step(4'hE, 1'b0, 1'b0, 2'd0, 8'd0);
      chk("frz_e5_tick", tick, 4'hE);
      chk("frz_e5_tick3", tick3, 3'h6);
      for (int i = 0; i < 3; i++) begin
         step(4'hE, 1'b0, 1'b0, 2'd0, 8'd0);
         chk($sformatf("frz_tick0_%0d", i), tick[0], 1'b0);
      end
      chk("frz_clk0", clkout[0], 1'b0);
      step(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
      step(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
      chk("frz_e10_tick", tick, 4'hE);
      chk("frz_e10_tick3", tick3, 3'h6);
      step(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
      chk("frz_e11_tick", tick, 4'h1);
      chk("frz_e11_tick3", tick3, 3'h1);
      chk("bad_sel_pend3_end", pending3, 3'h0);

      // D=1 on ch1, then reset mid-run overriding a simultaneous write.
      exp6 = '{1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      step(4'hF, 1'b0, 1'b1, 2'd1, 8'd1);
      chk("d1_pend", pending, 4'h2);
      for (int i = 0; i < 4; i++) step(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
      chk("d1_commit_tick", tick, 4'hF);
      chk("d1_commit_pend", pending, 4'h0);
      for (int i = 0; i < 4; i++) begin
         step(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
         chk($sformatf("d1_tick1_%0d", i), tick[1], 1'b1);
         chk($sformatf("d1_clk1_%0d", i), clkout[1], exp6[i]);
      end
      @(negedge clkin);
      reset = 1'b1; div_wr = 1'b1; div_ch = 2'd1; div_val = 8'd9; sync = 1'b1;
      @(posedge clkin);
      #1;
      chk("mid_rst_tick", tick, 4'h0);
      chk("mid_rst_clkout", clkout, 4'h0);
      chk("mid_rst_pending", pending, 4'h0);
      @(negedge clkin);
      reset = 1'b0; div_wr = 1'b0; sync = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
